// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - RV32I integer register file with pending-bit scoreboard and write bypass
//
// Purpose:
//   Multi-read-port register file that sits between decode and writeback.
//   Each register carries a pending bit that is set when a producer is
//   allocated and cleared when that producer writes back. Read ports are
//   combinational and report whether the operand is ready. After every reset
//   an init sequencer clears one entry per cycle; all traffic is ignored
//   until it finishes.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   r_addr     in   NUM_READ*ADDR_W    read addresses, port p at [p*ADDR_W +: ADDR_W]
//   r_data     out  NUM_READ*DATA_WIDTH read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   r_ready    out  NUM_READ           operand valid with no pending producer
//   w_en       in   writeback enable
//   w_addr     in   writeback address
//   w_data     in   writeback data
//   alloc_en   in   mark alloc_addr as pending
//   alloc_addr in   register to mark pending
//   init_done  out  high once the clear sequence has completed

module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    localparam int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_W-1:0]     r_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] r_data,
    output logic [NUM_READ-1:0]            r_ready,
    input  logic                           w_en,
    input  logic [ADDR_W-1:0]              w_addr,
    input  logic [DATA_WIDTH-1:0]          w_data,
    input  logic                           alloc_en,
    input  logic [ADDR_W-1:0]              alloc_addr,
    output logic                           init_done
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REGS-1:0]     pend_q, pend_d;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];

    logic run;
    logic wr_ok;
    logic al_ok;

    // A "real" register is in range and not x0; everything else reads as a
    // constant zero that is always ready and absorbs writes and allocs.
    function automatic logic real_reg(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && (a != '0);
    endfunction

    assign run       = (state_q == S_RUN);
    assign init_done = run;
    assign wr_ok     = run && w_en && real_reg(w_addr);
    assign al_ok     = run && alloc_en && real_reg(alloc_addr);

    // ------------------------------------------------------------------
    // Init sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_INIT) begin
            if (ptr_q == LAST_PTR) begin
                state_d = S_RUN;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: the write clears first, the alloc sets afterwards, so a
    // same-cycle alloc to the written register leaves it pending (the alloc
    // belongs to a younger instruction).
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[w_addr] = 1'b0;
        end
        if (al_ok) begin
            pend_d[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset on the array itself; the sequencer clears it.
    // A write that coincides with the reset edge is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_ok) begin
                mem_q[w_addr] <= w_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              ra_real;
        logic              byp;

        assign ra      = r_addr[p*ADDR_W +: ADDR_W];
        assign ra_real = real_reg(ra);
        // wr_ok already excludes x0 and out-of-range addresses.
        assign byp     = (BYPASS != 0) && wr_ok && (w_addr == ra);

        assign r_data[p*DATA_WIDTH +: DATA_WIDTH] =
            (!run || !ra_real) ? '0 :
            byp                ? w_data :
                                 mem_q[ra];

        assign r_ready[p] = run && (!ra_real || byp || !pend_q[ra]);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default instance (32 regs, 2 ports, bypass on)
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rrdy;
    logic        a_wen;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        a_aen;
    logic [4:0]  a_aaddr;
    logic        a_done;

    // bypass off instance
    logic [9:0]  b_raddr;
    logic [63:0] b_rdata;
    logic [1:0]  b_rrdy;
    logic        b_wen;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_aen;
    logic [4:0]  b_aaddr;
    logic        b_done;

    // 20 regs, 3 ports, 64-bit
    logic [14:0]  c_raddr;
    logic [191:0] c_rdata;
    logic [2:0]   c_rrdy;
    logic         c_wen;
    logic [4:0]   c_waddr;
    logic [63:0]  c_wdata;
    logic         c_aen;
    logic [4:0]   c_aaddr;
    logic         c_done;

    regfile_scoreboard u_a (
        .clk(clk), .rst(rst), .r_addr(a_raddr), .r_data(a_rdata), .r_ready(a_rrdy),
        .w_en(a_wen), .w_addr(a_waddr), .w_data(a_wdata),
        .alloc_en(a_aen), .alloc_addr(a_aaddr), .init_done(a_done)
    );

    regfile_scoreboard #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .r_addr(b_raddr), .r_data(b_rdata), .r_ready(b_rrdy),
        .w_en(b_wen), .w_addr(b_waddr), .w_data(b_wdata),
        .alloc_en(b_aen), .alloc_addr(b_aaddr), .init_done(b_done)
    );

    regfile_scoreboard #(.DATA_WIDTH(64), .NUM_REGS(20), .NUM_READ(3)) u_c (
        .clk(clk), .rst(rst), .r_addr(c_raddr), .r_data(c_rdata), .r_ready(c_rrdy),
        .w_en(c_wen), .w_addr(c_waddr), .w_data(c_wdata),
        .alloc_en(c_aen), .alloc_addr(c_aaddr), .init_done(c_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        aen;
        logic [4:0]  aaddr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
    } vec_t;

    function automatic vec_t mk(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic aen, input logic [4:0] aaddr,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] rdy);
        vec_t v;
        v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.aen = aen; v.aaddr = aaddr;
        v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
        return v;
    endfunction

    localparam int NVEC = 14;
    vec_t tbl [NVEC];

    initial begin
        // Each row: inputs driven for one cycle, outputs checked before the edge.
        tbl[0]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd5,  5'd5,  32'h0,        32'h0,        2'b11);
        tbl[1]  = mk(1, 5'd7,  32'h12345678, 0, 5'd0,  5'd3,  5'd3,  32'h0,        32'h0,        2'b11);
        tbl[2]  = mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 2'b11);
        tbl[3]  = mk(0, 5'd0,  32'h0,        1, 5'd9,  5'd0,  5'd0,  32'h0,        32'h0,        2'b11);
        tbl[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd10, 32'h0,        32'h0,        2'b10);
        tbl[5]  = mk(1, 5'd9,  32'hA5A5A5A5, 0, 5'd0,  5'd9,  5'd10, 32'hA5A5A5A5, 32'h0,        2'b11);
        tbl[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11);
        tbl[7]  = mk(1, 5'd9,  32'h11112222, 1, 5'd9,  5'd1,  5'd2,  32'h0,        32'h0,        2'b11);
        tbl[8]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd9,  32'h11112222, 32'h11112222, 2'b00);
        tbl[9]  = mk(0, 5'd0,  32'h0,        1, 5'd4,  5'd0,  5'd0,  32'h0,        32'h0,        2'b11);
        tbl[10] = mk(1, 5'd4,  32'hCAFEBABE, 0, 5'd0,  5'd4,  5'd9,  32'hCAFEBABE, 32'h11112222, 2'b01);
        tbl[11] = mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd4,  5'd4,  32'hCAFEBABE, 32'hCAFEBABE, 2'b11);
        tbl[12] = mk(1, 5'd31, 32'h00000031, 1, 5'd31, 5'd31, 5'd31, 32'h00000031, 32'h00000031, 2'b11);
        tbl[13] = mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd31, 5'd31, 32'h00000031, 32'h00000031, 2'b00);

        rst = 1'b1;
        a_raddr = '0; a_wen = 0; a_waddr = '0; a_wdata = '0; a_aen = 0; a_aaddr = '0;
        b_raddr = '0; b_wen = 0; b_waddr = '0; b_wdata = '0; b_aen = 0; b_aaddr = '0;
        c_raddr = '0; c_wen = 0; c_waddr = '0; c_wdata = '0; c_aen = 0; c_aaddr = '0;

        step();
        step();
        rst = 1'b0;

        // ---- init sequence: i edges have elapsed since reset released ----
        for (int i = 0; i <= 32; i++) begin
            if (i == 10) begin
                a_wen = 1; a_waddr = 5'd3; a_wdata = 32'hDEAD;
                a_aen = 1; a_aaddr = 5'd3;
                a_raddr = {5'd20, 5'd3};
            end
            if (i == 11) begin
                a_wen = 0; a_aen = 0; a_raddr = '0;
            end
            #1;
            chk($sformatf("init_done_a_%0d", i), 256'(a_done), 256'(i >= 32));
            chk($sformatf("init_done_c_%0d", i), 256'(c_done), 256'(i >= 20));
            if (i == 10) begin
                chk("init_rdata", 256'(a_rdata), 256'(0));
                chk("init_rready", 256'(a_rrdy), 256'(0));
            end
            if (i < 32) step();
        end
        chk("init_done_b", 256'(b_done), 256'(1));

        // ---- table-driven vectors on the default instance ----
        for (int i = 0; i < NVEC; i++) begin
            a_wen = tbl[i].wen; a_waddr = tbl[i].waddr; a_wdata = tbl[i].wdata;
            a_aen = tbl[i].aen; a_aaddr = tbl[i].aaddr;
            a_raddr = {tbl[i].ra1, tbl[i].ra0};
            #1;
            chk($sformatf("vec%0d_d0", i), 256'(a_rdata[31:0]), 256'(tbl[i].d0));
            chk($sformatf("vec%0d_d1", i), 256'(a_rdata[63:32]), 256'(tbl[i].d1));
            chk($sformatf("vec%0d_rdy", i), 256'(a_rrdy), 256'(tbl[i].rdy));
            step();
        end
        a_wen = 0; a_aen = 0;

        // ---- bypass disabled: same-cycle write not forwarded ----
        b_wen = 1; b_waddr = 5'd4; b_wdata = 32'h55;
        step();
        b_wen = 0; b_aen = 1; b_aaddr = 5'd4;
        step();
        b_aen = 0; b_wen = 1; b_waddr = 5'd4; b_wdata = 32'hCAFEBABE;
        b_raddr = {5'd4, 5'd4};
        #1;
        chk("nobyp_old_data", 256'(b_rdata), {192'd0, 32'h55, 32'h55});
        chk("nobyp_old_rdy", 256'(b_rrdy), 256'(2'b00));
        step();
        b_wen = 0;
        #1;
        chk("nobyp_new_data", 256'(b_rdata), {192'd0, 32'hCAFEBABE, 32'hCAFEBABE});
        chk("nobyp_new_rdy", 256'(b_rrdy), 256'(2'b11));

        // ---- 20 regs / 3 ports / 64-bit ----
        c_wen = 1; c_waddr = 5'd25; c_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        c_aen = 1; c_aaddr = 5'd25;
        c_raddr = {5'd19, 5'd19, 5'd25};
        #1;
        chk("big_oor_data", 256'(c_rdata[63:0]), 256'(0));
        chk("big_oor_rdy", 256'(c_rrdy[0]), 256'(1));
        step();
        c_aen = 0; c_wen = 1; c_waddr = 5'd19; c_wdata = 64'h0123_4567_89AB_CDEF;
        step();
        c_wen = 0;
        c_raddr = {5'd19, 5'd19, 5'd19};
        #1;
        chk("big_x19_data", 256'(c_rdata), {64'd0, {3{64'h0123_4567_89AB_CDEF}}});
        chk("big_x19_rdy", 256'(c_rrdy), 256'(3'b111));
        c_raddr = {5'd19, 5'd19, 5'd25};
        #1;
        chk("big_oor_after", 256'(c_rdata[63:0]), 256'(0));
        chk("big_oor_after_rdy", 256'(c_rrdy), 256'(3'b111));

        // ---- reset mid-operation ----
        a_wen = 1; a_waddr = 5'd1; a_wdata = 32'h1; step();
        a_waddr = 5'd2; a_wdata = 32'h2; step();
        a_waddr = 5'd3; a_wdata = 32'h3; step();
        a_wen = 0; a_aen = 1; a_aaddr = 5'd2; step();
        a_aen = 0;
        a_raddr = {5'd2, 5'd1};
        #1;
        chk("pre_rst_data", 256'(a_rdata), {192'd0, 32'h2, 32'h1});
        chk("pre_rst_rdy", 256'(a_rrdy), 256'(2'b01));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_done_low", 256'(a_done), 256'(0));
        chk("rst_rdy_low", 256'(a_rrdy), 256'(0));
        for (int i = 0; i < 31; i++) step();
        chk("rst_done_31", 256'(a_done), 256'(0));
        step();
        chk("rst_done_32", 256'(a_done), 256'(1));
        a_raddr = {5'd2, 5'd1};
        #1;
        chk("post_rst_x1x2", 256'(a_rdata), 256'(0));
        chk("post_rst_rdy12", 256'(a_rrdy), 256'(2'b11));
        a_raddr = {5'd3, 5'd3};
        #1;
        chk("post_rst_x3", 256'(a_rdata), 256'(0));
        chk("post_rst_rdy3", 256'(a_rrdy), 256'(2'b11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-read-port integer register file for the RV32I core, with a per-register pending (scoreboard) bit and optional write-to-read bypass.
- After every reset, a hardware init sequencer clears the storage one entry per cycle.
- Sits between decode (read ports, destination allocation) and writeback (write port).
- Supplies operand data plus a ready flag that tells the issue logic whether an operand is still waiting on an in-flight producer.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers; minimum 2, need not be a power of two.
- NUM_READ, 2, number of independent combinational read ports; minimum 1.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 it is not forwarded.
- ADDR_W (localparam), $clog2(NUM_REGS), address width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- r_addr  in  NUM_READ*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- r_data  out  NUM_READ*DATA_WIDTH  read data; port p uses bits [p*DATA_WIDTH +: DATA_WIDTH].
- r_ready  out  NUM_READ  per-port flag: operand valid, no pending producer.
- w_en  in  1  writeback enable.
- w_addr  in  ADDR_W  writeback address.
- w_data  in  DATA_WIDTH  writeback data.
- alloc_en  in  1  mark a destination register as pending (instruction issued).
- alloc_addr  in  ADDR_W  register to mark pending.
- init_done  out  1  high once the clear sequence has finished; all traffic is ignored while low.

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - state <= INIT, init_ptr <= 0, all pending bits <= 0, init_done <= 0.
  - rst asserted mid-operation behaves identically; any in-flight state is discarded.
- FSM states: INIT, RUN.
  - INIT: each cycle writes mem[init_ptr] <= 0 and increments init_ptr.
  - When init_ptr == NUM_REGS-1, the write completes and state <= RUN, init_done <= 1 on the same edge.
  - init_done therefore first reads 1 exactly NUM_REGS cycles after the first edge with rst=0.
  - RUN is held until the next rst.
- Behaviour while in INIT:
  - w_en and alloc_en are ignored.
  - All r_data read 0 and all r_ready read 0.
- Register 0:
  - Always reads 0 with r_ready=1.
  - Writes and allocs to address 0 are ignored; its pending bit never sets.
- Out-of-range addresses (>= NUM_REGS):
  - Reads return 0 with r_ready=1.
  - Writes and allocs to them are ignored.
- Write (RUN): when w_en=1 and w_addr is valid and nonzero, mem[w_addr] <= w_data and pending[w_addr] <= 0 at the edge.
- Alloc (RUN): when alloc_en=1 and alloc_addr is valid and nonzero, pending[alloc_addr] <= 1 at the edge.
- Alloc and write to the same address in the same cycle:
  - Data is stored.
  - Pending ends at 1, because the alloc is a newer producer and alloc wins.
- Read path (combinational, zero latency) for each port p in RUN:
  - If BYPASS=1, w_en=1 and w_addr == r_addr_p (nonzero, valid): r_data_p = w_data, r_ready_p = 1.
  - Otherwise: r_data_p = mem[r_addr_p], r_ready_p = ~pending[r_addr_p].
  - With BYPASS=0, a read in the same cycle as a write returns the old value, with ready taken from the pre-edge pending bit.
  - All read ports are fully independent; identical addresses on several ports are legal.
- No read-modify-write arithmetic; data is stored verbatim at DATA_WIDTH bits.

Test Plan:
1. Reset, then idle with default parameters:
   - init_done=0 for exactly 32 cycles after rst deasserts, then 1.
   - A read of x5 then returns 0 with r_ready=1.
   - During INIT, w_en=1 with w_addr=3, w_data=0xDEAD is ignored; x3 reads 0 afterwards.
2. Basic write/read:
   - Write x7=0x12345678, then read x7 on both ports -> 0x12345678, r_ready=2'b11.
   - Write x0=0xFFFFFFFF -> x0 still reads 0.
3. Scoreboard:
   - alloc x9 -> next cycle r_ready for x9 is 0 while x10 is still ready.
   - Write x9=0xA5A5A5A5 -> next cycle r_ready=1 and data 0xA5A5A5A5.
   - alloc + write x9 in the same cycle -> data stored, r_ready for x9 stays 0.
4. Bypass:
   - BYPASS=1: x4 pending, same-cycle w_en to x4 with data 0xCAFEBABE -> r_data=0xCAFEBABE, r_ready=1 in that cycle.
   - BYPASS=0: same stimulus -> old value with r_ready=0 in that cycle; new value with r_ready=1 the next cycle.
5. Reset mid-operation:
   - After writing x1..x3 and allocating x2, assert rst for 1 cycle.
   - init_done drops, and after 32 cycles x1..x3 read 0 with all ready.
6. Non-default parameters:
   - NUM_REGS=20, NUM_READ=3, DATA_WIDTH=64 -> init takes 20 cycles.
   - Read of address 25 -> 0, ready=1.
   - A 64-bit write to x19 is read correctly on all 3 ports.
